// File: rtl/fb_pkg.sv
// Shared framebuffer geometry, arbiter state encoding and pixel-write record
// for the framebuffer memory arbiter slice.
package fb_pkg;
   localparam int FB_W       = 64;
   localparam int FB_H       = 48;
   localparam int PIX_W      = 4;
   localparam int WORD_PIX   = 8;
   localparam int FB_WORDS   = FB_W * FB_H / WORD_PIX;
   localparam int ADDR_W     = 9;
   localparam int FIFO_DEPTH = 4;
   localparam int CNT_W      = $clog2(FIFO_DEPTH) + 1;

   typedef enum logic [1:0] {
      S_IDLE      = 2'd0,
      S_FILL_WAIT = 2'd1,
      S_FILL      = 2'd2
   } arb_state_t;

   typedef struct packed {
      logic [5:0] x;
      logic [5:0] y;
      logic [3:0] colour;
   } pix_wr_t;

   function automatic logic pix_in_range(input logic [5:0] x, input logic [5:0] y);
      return ({1'b0, x} < 7'(FB_W)) && ({1'b0, y} < 7'(FB_H));
   endfunction

   // Row-major word address: y*8 + x/8 as a pure bit concatenation
   function automatic logic [ADDR_W-1:0] pix_word_addr(input pix_wr_t p);
      return {p.y, p.x[5:3]};
   endfunction

   function automatic logic [31:0] colour_rep(input logic [3:0] c);
      return {8{c}};
   endfunction
endpackage

// File: rtl/fb_mem_arbiter_if.sv
// Display, pixel-write, fill and SRAM signals of the framebuffer arbiter;
// slave is the arbiter side, master the surrounding logic.
interface fb_mem_arbiter_if;
   logic                       disp_mem_row;
   logic                       disp_mem_read;
   logic [fb_pkg::ADDR_W-1:0]  disp_addr;
   logic [2:0]                 disp_pix_sel;
   logic [fb_pkg::PIX_W-1:0]   disp_pixel;
   logic                       wr_valid;
   logic                       wr_ready;
   logic [5:0]                 wr_x;
   logic [5:0]                 wr_y;
   logic [3:0]                 wr_colour;
   logic                       wr_drop;
   logic                       fill_start;
   logic [3:0]                 fill_colour;
   logic                       fill_busy;
   logic                       mem_en;
   logic                       mem_we;
   logic [fb_pkg::ADDR_W-1:0]  mem_addr;
   logic [31:0]                mem_wdata;
   logic [7:0]                 mem_wmask;
   logic [31:0]                mem_rdata;

   modport slave (
      input  disp_mem_row, disp_mem_read, disp_addr, disp_pix_sel,
      input  wr_valid, wr_x, wr_y, wr_colour, fill_start, fill_colour, mem_rdata,
      output disp_pixel, wr_ready, wr_drop, fill_busy,
      output mem_en, mem_we, mem_addr, mem_wdata, mem_wmask
   );

   modport master (
      output disp_mem_row, disp_mem_read, disp_addr, disp_pix_sel,
      output wr_valid, wr_x, wr_y, wr_colour, fill_start, fill_colour, mem_rdata,
      input  disp_pixel, wr_ready, wr_drop, fill_busy,
      input  mem_en, mem_we, mem_addr, mem_wdata, mem_wmask
   );
endinterface

// File: rtl/fb_wr_fifo.sv
// Small synchronous FIFO of pending pixel writes; push and pop may coincide.
module fb_wr_fifo
   import fb_pkg::*;
(
   input  logic             clk_25,
   input  logic             rst_n,
   input  logic             push,
   input  pix_wr_t          push_data,
   input  logic             pop,
   output pix_wr_t          head,
   output logic             full,
   output logic             empty,
   output logic [CNT_W-1:0] count
);
   localparam int PTR_W = $clog2(FIFO_DEPTH);

   pix_wr_t          store_r [FIFO_DEPTH];
   logic [PTR_W-1:0] wr_ptr_r;
   logic [PTR_W-1:0] rd_ptr_r;
   logic [CNT_W-1:0] count_r;
   logic             push_s;
   logic             pop_s;

   assign full   = (count_r == CNT_W'(FIFO_DEPTH));
   assign empty  = (count_r == {CNT_W{1'b0}});
   assign count  = count_r;
   assign head   = store_r[rd_ptr_r];
   assign push_s = push && !full;
   assign pop_s  = pop && !empty;

   // Pointer and occupancy tracking
   always_ff @(posedge clk_25 or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_r <= {PTR_W{1'b0}};
         rd_ptr_r <= {PTR_W{1'b0}};
         count_r  <= {CNT_W{1'b0}};
      end else begin
         if (push_s) begin
            wr_ptr_r <= wr_ptr_r + PTR_W'(1);
         end
         if (pop_s) begin
            rd_ptr_r <= rd_ptr_r + PTR_W'(1);
         end
         case ({push_s, pop_s})
            2'b10:   count_r <= count_r + CNT_W'(1);
            2'b01:   count_r <= count_r - CNT_W'(1);
            default: count_r <= count_r;
         endcase
      end
   end

   // Entry storage; contents are don't-care until pushed
   always_ff @(posedge clk_25) begin
      if (push_s) begin
         store_r[wr_ptr_r] <= push_data;
      end
   end
endmodule

// File: rtl/fb_mem_arbiter.sv
// Framebuffer SRAM arbiter: display reads pass straight through, queued pixel
// writes and full-screen fills use only the cycles outside display rows.
module fb_mem_arbiter
   import fb_pkg::*;
(
   input  logic             clk_25,
   input  logic             rst_n,
   fb_mem_arbiter_if.slave  bus
);
   localparam logic [ADDR_W-1:0] FILL_LAST = ADDR_W'(FB_WORDS - 1);

   arb_state_t        state_r;
   logic [ADDR_W-1:0] fill_cnt_r;
   logic [3:0]        fill_colour_r;
   logic              wr_drop_r;
   logic              fill_busy_r;

   pix_wr_t           fifo_head_s;
   logic              fifo_full_s;
   logic              fifo_empty_s;
   logic [CNT_W-1:0]  fifo_count_s;
   logic              wr_ready_s;
   logic              wr_acc_s;
   logic              in_range_s;
   logic              push_s;
   logic              pop_s;
   logic              fill_grant_s;
   logic              mem_en_s;
   logic              mem_we_s;
   logic [ADDR_W-1:0] mem_addr_s;
   logic [31:0]       mem_wdata_s;
   logic [7:0]        mem_wmask_s;

   assign wr_ready_s   = !fifo_full_s && (state_r == S_IDLE);
   assign wr_acc_s     = bus.wr_valid && wr_ready_s;
   assign in_range_s   = pix_in_range(bus.wr_x, bus.wr_y);
   assign push_s       = wr_acc_s && in_range_s;
   // Queued writes keep draining while a fill waits for the FIFO to empty
   assign pop_s        = !bus.disp_mem_row && (state_r != S_FILL) && !fifo_empty_s;
   assign fill_grant_s = !bus.disp_mem_row && (state_r == S_FILL);

   fb_wr_fifo u_fifo (
      .clk_25    (clk_25),
      .rst_n     (rst_n),
      .push      (push_s),
      .push_data ('{x: bus.wr_x, y: bus.wr_y, colour: bus.wr_colour}),
      .pop       (pop_s),
      .head      (fifo_head_s),
      .full      (fifo_full_s),
      .empty     (fifo_empty_s),
      .count     (fifo_count_s)
   );

   // SRAM port mux: display row first, then fill, then queued pixel write
   always_comb begin
      mem_en_s    = 1'b0;
      mem_we_s    = 1'b0;
      mem_addr_s  = {ADDR_W{1'b0}};
      mem_wdata_s = 32'h0000_0000;
      mem_wmask_s = 8'h00;
      if (bus.disp_mem_row) begin
         mem_en_s   = bus.disp_mem_read;
         mem_addr_s = bus.disp_addr;
      end else if (fill_grant_s) begin
         mem_en_s    = 1'b1;
         mem_we_s    = 1'b1;
         mem_addr_s  = fill_cnt_r;
         mem_wdata_s = colour_rep(fill_colour_r);
         mem_wmask_s = 8'hFF;
      end else if (pop_s) begin
         mem_en_s    = 1'b1;
         mem_we_s    = 1'b1;
         mem_addr_s  = pix_word_addr(fifo_head_s);
         mem_wdata_s = colour_rep(fifo_head_s.colour);
         mem_wmask_s = 8'h01 << fifo_head_s.x[2:0];
      end else begin
         mem_en_s = 1'b0;
      end
   end

   // Arbiter FSM, fill counter and registered status flags
   always_ff @(posedge clk_25 or negedge rst_n) begin
      if (!rst_n) begin
         state_r       <= S_IDLE;
         fill_cnt_r    <= {ADDR_W{1'b0}};
         fill_colour_r <= 4'h0;
         wr_drop_r     <= 1'b0;
         fill_busy_r   <= 1'b0;
      end else begin
         wr_drop_r <= wr_acc_s && !in_range_s;
         case (state_r)
            S_IDLE: begin
               if (bus.fill_start) begin
                  state_r       <= S_FILL_WAIT;
                  fill_colour_r <= bus.fill_colour;
                  fill_busy_r   <= 1'b1;
               end
            end
            S_FILL_WAIT: begin
               if (fifo_count_s == {CNT_W{1'b0}}) begin
                  state_r <= S_FILL;
               end
            end
            S_FILL: begin
               if (fill_grant_s) begin
                  if (fill_cnt_r == FILL_LAST) begin
                     state_r     <= S_IDLE;
                     fill_cnt_r  <= {ADDR_W{1'b0}};
                     fill_busy_r <= 1'b0;
                  end else begin
                     fill_cnt_r <= fill_cnt_r + ADDR_W'(1);
                  end
               end
            end
            default: begin
               state_r     <= S_IDLE;
               fill_cnt_r  <= {ADDR_W{1'b0}};
               fill_busy_r <= 1'b0;
            end
         endcase
      end
   end

   assign bus.disp_pixel = bus.mem_rdata[{bus.disp_pix_sel, 2'b00} +: PIX_W];
   assign bus.wr_ready   = wr_ready_s;
   assign bus.wr_drop    = wr_drop_r;
   assign bus.fill_busy  = fill_busy_r;
   assign bus.mem_en     = mem_en_s;
   assign bus.mem_we     = mem_we_s;
   assign bus.mem_addr   = mem_addr_s;
   assign bus.mem_wdata  = mem_wdata_s;
   assign bus.mem_wmask  = mem_wmask_s;
endmodule

// File: tb/tb_fb_mem_arbiter.sv
// Bench for fb_mem_arbiter: vector tables for display and single writes, a
// write scoreboard checked on every SRAM write, and fill/reset sequences.
module tb_fb_mem_arbiter;
   import fb_pkg::*;

   typedef struct {
      logic [8:0]  addr;
      logic [31:0] data;
      logic [7:0]  mask;
   } wr_exp_t;

   typedef struct {
      logic        row;
      logic        rd;
      logic [8:0]  addr;
      logic [2:0]  sel;
      logic [31:0] rdata;
      logic [3:0]  pix;
      logic        en;
   } disp_vec_t;

   typedef struct {
      logic [5:0] x;
      logic [5:0] y;
      logic [3:0] c;
      logic       drop;
   } wr_vec_t;

   logic clk_25 = 1'b0;
   logic rst_n  = 1'b0;
   always #20 clk_25 = ~clk_25;

   fb_mem_arbiter_if bus();
   fb_mem_arbiter dut (.clk_25(clk_25), .rst_n(rst_n), .bus(bus));

   wr_exp_t   sb[$];
   wr_exp_t   mon_e;
   disp_vec_t dv[6];
   wr_vec_t   wv[7];
   int n_checks = 0;
   int n_err    = 0;
   int n_wr     = 0;
   int cyc      = 0;
   int last383_cyc = -100;

   always @(posedge clk_25) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic fail_now(input string name);
      n_checks++;
      n_err++;
      $display("FAIL %s: timed out waiting for DUT", name);
   endtask

   task automatic tick();
      @(posedge clk_25);
      #1;
   endtask

   task automatic sample();
      @(negedge clk_25);
      #1;
   endtask

   function automatic wr_exp_t model_pix(input int x, input int y, input logic [3:0] c);
      wr_exp_t e;
      e.addr = 9'(y * 8 + x / 8);
      e.mask = 8'(1 << (x % 8));
      e.data = 32'(c) * 32'h1111_1111;
      return e;
   endfunction

   task automatic push_fill(input logic [3:0] c);
      wr_exp_t e;
      for (int a = 0; a < FB_WORDS; a++) begin
         e.addr = 9'(a);
         e.data = 32'(c) * 32'h1111_1111;
         e.mask = 8'hFF;
         sb.push_back(e);
      end
   endtask

   // Scoreboard: every SRAM write must match the oldest expected write
   always @(negedge clk_25) begin
      if (rst_n === 1'b1) begin
         if (bus.disp_mem_row) chk("no_we_in_row", 64'(bus.mem_we), 64'd0);
         if (bus.mem_en && bus.mem_we) begin
            n_wr++;
            if (bus.mem_addr == 9'd383) last383_cyc = cyc;
            if (sb.size() == 0) begin
               n_checks++;
               n_err++;
               $display("FAIL unexpected_write: got addr %0d data %h mask %h, expected none",
                        bus.mem_addr, bus.mem_wdata, bus.mem_wmask);
            end else begin
               mon_e = sb.pop_front();
               chk("mem_write", {15'd0, bus.mem_addr, bus.mem_wdata, bus.mem_wmask},
                   {15'd0, mon_e.addr, mon_e.data, mon_e.mask});
            end
         end
      end
   end

   initial begin
      #2ms;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int base;
      bit done;

      dv[0] = '{1'b1, 1'b1, 9'd7,   3'd6, 32'h0F00_0000, 4'hF, 1'b1};
      dv[1] = '{1'b1, 1'b1, 9'd383, 3'd0, 32'h1234_567A, 4'hA, 1'b1};
      dv[2] = '{1'b1, 1'b0, 9'd100, 3'd7, 32'h9ABC_DEF0, 4'h9, 1'b0};
      dv[3] = '{1'b0, 1'b1, 9'd5,   3'd3, 32'h0000_F000, 4'hF, 1'b0};
      dv[4] = '{1'b1, 1'b1, 9'd256, 3'd1, 32'h0000_00B0, 4'hB, 1'b1};
      dv[5] = '{1'b0, 1'b0, 9'd0,   3'd2, 32'h0000_0C00, 4'hC, 1'b0};

      wv[0] = '{6'd13, 6'd5,  4'hA, 1'b0};
      wv[1] = '{6'd0,  6'd0,  4'h1, 1'b0};
      wv[2] = '{6'd63, 6'd47, 4'hF, 1'b0};
      wv[3] = '{6'd10, 6'd48, 4'h5, 1'b1};
      wv[4] = '{6'd7,  6'd63, 4'h2, 1'b1};
      wv[5] = '{6'd8,  6'd0,  4'hC, 1'b0};
      wv[6] = '{6'd31, 6'd20, 4'h6, 1'b0};

      bus.disp_mem_row = 1'b0; bus.disp_mem_read = 1'b0; bus.disp_addr = 9'd0;
      bus.disp_pix_sel = 3'd0; bus.wr_valid = 1'b0; bus.wr_x = 6'd0; bus.wr_y = 6'd0;
      bus.wr_colour = 4'h0; bus.fill_start = 1'b0; bus.fill_colour = 4'h0;
      bus.mem_rdata = 32'h0;

      // Reset state
      repeat (2) @(posedge clk_25);
      sample();
      chk("rst_wr_ready", 64'(bus.wr_ready), 64'd1);
      chk("rst_mem_en", 64'(bus.mem_en), 64'd0);
      chk("rst_mem_we", 64'(bus.mem_we), 64'd0);
      chk("rst_fill_busy", 64'(bus.fill_busy), 64'd0);
      chk("rst_wr_drop", 64'(bus.wr_drop), 64'd0);
      tick();
      rst_n = 1'b1;
      repeat (2) tick();
      chk("idle_mem_en", 64'(bus.mem_en), 64'd0);

      // Display pass-through table
      for (int i = 0; i < 6; i++) begin
         tick();
         bus.disp_mem_row  = dv[i].row;
         bus.disp_mem_read = dv[i].rd;
         bus.disp_addr     = dv[i].addr;
         bus.disp_pix_sel  = dv[i].sel;
         bus.mem_rdata     = dv[i].rdata;
         #2;
         chk("disp_pixel", 64'(bus.disp_pixel), 64'(dv[i].pix));
         chk("disp_mem_en", 64'(bus.mem_en), 64'(dv[i].en));
         chk("disp_mem_we", 64'(bus.mem_we), 64'd0);
         if (dv[i].row) chk("disp_mem_addr", 64'(bus.mem_addr), 64'(dv[i].addr));
         if (dv[i].row) chk("disp_wmask", 64'(bus.mem_wmask), 64'd0);
      end
      tick();
      bus.disp_mem_row = 1'b0;
      bus.disp_mem_read = 1'b0;

      // Single pixel writes, including out-of-range drops
      for (int i = 0; i < 7; i++) begin
         tick();
         bus.wr_x = wv[i].x; bus.wr_y = wv[i].y; bus.wr_colour = wv[i].c;
         bus.wr_valid = 1'b1;
         if (int'(wv[i].x) < 64 && int'(wv[i].y) < 48)
            sb.push_back(model_pix(int'(wv[i].x), int'(wv[i].y), wv[i].c));
         tick();
         bus.wr_valid = 1'b0;
         sample();
         chk("wr_drop_pulse", 64'(bus.wr_drop), 64'(wv[i].drop));
         tick();
         sample();
         chk("wr_drop_clear", 64'(bus.wr_drop), 64'd0);
         chk("fifo_drained", 64'(bus.mem_en), 64'd0);
      end

      // Fill the FIFO during a display row, then drain in order
      tick();
      bus.disp_mem_row = 1'b1;
      for (int i = 0; i < 4; i++) begin
         bus.wr_x = 6'(8 * i + i); bus.wr_y = 6'(10 + i); bus.wr_colour = 4'(i + 2);
         bus.wr_valid = 1'b1;
         #1;
         chk("full_ready_before", 64'(bus.wr_ready), 64'd1);
         sb.push_back(model_pix(8 * i + i, 10 + i, 4'(i + 2)));
         tick();
      end
      bus.wr_valid = 1'b0;
      #1;
      chk("full_ready_low", 64'(bus.wr_ready), 64'd0);
      repeat (3) tick();
      chk("full_still_blocked", 64'(bus.wr_ready), 64'd0);
      bus.disp_mem_row = 1'b0;
      base = n_wr;
      repeat (4) tick();
      sample();
      chk("drain_count", 64'(n_wr - base), 64'd4);
      chk("drain_ready", 64'(bus.wr_ready), 64'd1);

      // Fill with display rows toggling 10 high / 20 low; a second fill_start is ignored
      tick();
      bus.fill_start = 1'b1; bus.fill_colour = 4'h3;
      push_fill(4'h3);
      base = n_wr;
      tick();
      bus.fill_start = 1'b0;
      sample();
      chk("fill_busy_set", 64'(bus.fill_busy), 64'd1);
      done = 1'b0;
      for (int c = 0; c < 3000 && !done; c++) begin
         tick();
         bus.disp_mem_row = ((c % 30) < 10);
         bus.fill_start   = (c == 50);
         bus.fill_colour  = (c == 50) ? 4'h5 : 4'h3;
         sample();
         if (c == 5) chk("fill_wr_ready", 64'(bus.wr_ready), 64'd0);
         if (!bus.fill_busy) begin
            done = 1'b1;
            chk("fill_busy_fall", 64'(cyc), 64'(last383_cyc + 1));
         end
      end
      if (!done) fail_now("fill_toggle");
      bus.fill_start = 1'b0;
      bus.disp_mem_row = 1'b0;
      chk("fill_write_count", 64'(n_wr - base), 64'd384);
      chk("fill_sb_empty", 64'(sb.size()), 64'd0);

      // Write and fill_start together: the write lands before the fill
      tick();
      bus.wr_x = 6'd2; bus.wr_y = 6'd1; bus.wr_colour = 4'h7; bus.wr_valid = 1'b1;
      bus.fill_start = 1'b1; bus.fill_colour = 4'h9;
      sb.push_back(model_pix(2, 1, 4'h7));
      push_fill(4'h9);
      tick();
      bus.wr_valid = 1'b0; bus.fill_start = 1'b0;
      done = 1'b0;
      for (int c = 0; c < 1000 && !done; c++) begin
         sample();
         if (!bus.fill_busy) done = 1'b1;
      end
      if (!done) fail_now("fill_with_write");
      chk("fill2_sb_empty", 64'(sb.size()), 64'd0);

      // Reset in the middle of a fill
      tick();
      bus.fill_start = 1'b1; bus.fill_colour = 4'h6;
      push_fill(4'h6);
      base = n_wr;
      tick();
      bus.fill_start = 1'b0;
      done = 1'b0;
      for (int c = 0; c < 1000 && !done; c++) begin
         sample();
         if (n_wr - base >= 100) done = 1'b1;
      end
      if (!done) fail_now("fill_to_100");
      rst_n = 1'b0;
      #1;
      chk("rst_mid_fill_busy", 64'(bus.fill_busy), 64'd0);
      chk("rst_mid_fill_en", 64'(bus.mem_en), 64'd0);
      chk("rst_mid_fill_ready", 64'(bus.wr_ready), 64'd1);
      sb.delete();
      tick();
      rst_n = 1'b1;
      tick();
      sample();
      chk("post_rst_idle", 64'(bus.mem_en), 64'd0);
      chk("post_rst_busy", 64'(bus.fill_busy), 64'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
      $finish;
   end
endmodule
